tank_turn_engine: RTL

- Parametrised turn-based game-state engine for the two-tank artillery game.
- Holds each tank's one-hot position, life count, active-turn flag, per-turn move budget and game-over/winner status.
- Consumes debounced buttons, an active-low fire key and a hit verdict from the trajectory logic.
- Feeds the seven-segment mapping and scan logic downstream.

---
 rtl/tank_turn_engine.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/tank_turn_engine.sv
// tank_turn_engine
// ----------------
// Turn-based game-state engine for the two-tank artillery game. It tracks
// each tank's one-hot position, life count, whose turn it is, the move
// budget left in the current turn, and the game-over/winner status.
//
// Handshake: hit_valid is a one-cycle strobe that qualifies hit. It is only
// acted upon while a shot is outstanding (shot_pending = 1); a strobe at any
// other time is dropped. There is no back-pressure.
//
// Ports:
//   clk            in   system clock
//   nrst           in   asynchronous active-low reset
//   button[1:0]    in   level buttons; [1] toward higher index, [0] toward lower
//   fire           in   active-low fire key (falling edge = fire event)
//   hit_valid      in   one-cycle strobe, verdict on hit
//   hit            in   1 = opponent struck
//   restart        in   synchronous new-game request
//   tank1_location out  one-hot position of tank1
//   tank2_location out  one-hot position of tank2
//   tank1_life     out  remaining life of tank1
//   tank2_life     out  remaining life of tank2
//   turn           out  active tank (0 = tank1, 1 = tank2)
//   moves_left     out  remaining move budget this turn
//   shot_pending   out  waiting for a hit verdict
//   game_over      out  a life has reached 0
//   winner         out  valid with game_over (0 = tank1, 1 = tank2)
//
// The FSM state register is the named signal `state` (type state_t) so
// checkers can bind to it directly.
module tank_turn_engine #(
  parameter int NUM_POS   = 4,
  parameter int LIFE_W    = 2,
  parameter int INIT_LIFE = 3,
  parameter int MOVE_MAX  = 3,
  parameter int T1_INIT   = 2,
  parameter int T2_INIT   = 1,
  localparam int MW       = $clog2(MOVE_MAX + 1)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [1:0]         button,
  input  logic               fire,
  input  logic               hit_valid,
  input  logic               hit,
  input  logic               restart,
  output logic [NUM_POS-1:0] tank1_location,
  output logic [NUM_POS-1:0] tank2_location,
  output logic [LIFE_W-1:0]  tank1_life,
  output logic [LIFE_W-1:0]  tank2_life,
  output logic               turn,
  output logic [MW-1:0]      moves_left,
  output logic               shot_pending,
  output logic               game_over,
  output logic               winner
);

  typedef enum logic [1:0] {
    S_MOVE      = 2'd0,
    S_WAIT_HIT  = 2'd1,
    S_GAME_OVER = 2'd2
  } state_t;

  localparam logic [NUM_POS-1:0] LOC1_INIT = NUM_POS'(1) << T1_INIT;
  localparam logic [NUM_POS-1:0] LOC2_INIT = NUM_POS'(1) << T2_INIT;
  localparam logic [LIFE_W-1:0]  LIFE_INIT = LIFE_W'(INIT_LIFE);
  localparam logic [MW-1:0]      MOVES_INIT = MW'(MOVE_MAX);

  state_t       state;
  logic [1:0]   button_q;
  logic         fire_q;

  logic [1:0]         rise;
  logic               fire_ev;
  logic [NUM_POS-1:0] act_loc;
  logic [NUM_POS-1:0] act_loc_next;
  logic               can_up;
  logic               can_dn;
  logic [LIFE_W-1:0]  opp_life;
  logic [LIFE_W-1:0]  opp_life_next;

  always_comb begin
    rise    = button & ~button_q;
    fire_ev = fire_q & ~fire;
    act_loc = turn ? tank2_location : tank1_location;
    opp_life = turn ? tank1_life : tank2_life;
    // Saturating decrement: a hit on an already-dead tank cannot wrap.
    opp_life_next = (hit && (opp_life != '0)) ? opp_life - LIFE_W'(1) : opp_life;
    // Two buttons rising together cancel each other out.
    can_up = rise[1] & ~rise[0] & ~act_loc[NUM_POS-1] & (moves_left != '0);
    can_dn = rise[0] & ~rise[1] & ~act_loc[0]         & (moves_left != '0);
    act_loc_next = act_loc;
    if (can_up)      act_loc_next = act_loc << 1;
    else if (can_dn) act_loc_next = act_loc >> 1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state          <= S_MOVE;
      button_q       <= 2'b00;
      fire_q         <= 1'b1;
      tank1_location <= LOC1_INIT;
      tank2_location <= LOC2_INIT;
      tank1_life     <= LIFE_INIT;
      tank2_life     <= LIFE_INIT;
      turn           <= 1'b0;
      moves_left     <= MOVES_INIT;
      shot_pending   <= 1'b0;
      game_over      <= 1'b0;
      winner         <= 1'b0;
    end else if (restart) begin
      state          <= S_MOVE;
      button_q       <= 2'b00;
      fire_q         <= 1'b1;
      tank1_location <= LOC1_INIT;
      tank2_location <= LOC2_INIT;
      tank1_life     <= LIFE_INIT;
      tank2_life     <= LIFE_INIT;
      turn           <= 1'b0;
      moves_left     <= MOVES_INIT;
      shot_pending   <= 1'b0;
      game_over      <= 1'b0;
      winner         <= 1'b0;
    end else begin
      button_q <= button;
      fire_q   <= fire;
      case (state)
        S_MOVE: begin
          // Fire wins over a same-cycle move; the move is dropped.
          if (fire_ev) begin
            state        <= S_WAIT_HIT;
            shot_pending <= 1'b1;
          end else if (can_up || can_dn) begin
            if (turn) tank2_location <= act_loc_next;
            else      tank1_location <= act_loc_next;
            moves_left <= moves_left - MW'(1);
          end
        end
        S_WAIT_HIT: begin
          if (hit_valid) begin
            if (turn) tank1_life <= opp_life_next;
            else      tank2_life <= opp_life_next;
            shot_pending <= 1'b0;
            if (opp_life_next == '0) begin
              // Shooter keeps the turn; it is recorded as the winner.
              state     <= S_GAME_OVER;
              game_over <= 1'b1;
              winner    <= turn;
            end else begin
              state      <= S_MOVE;
              turn       <= ~turn;
              moves_left <= MOVES_INIT;
            end
          end
        end
        S_GAME_OVER: begin
          // Frozen until restart or reset.
        end
        default: state <= S_MOVE;
      endcase
    end
  end

endmodule
